// File: rtl/hex_display_bank.sv
// Multi-digit hex to seven-segment display bank. A load strobe captures the value,
// which is then decoded MSD-first, one digit per cycle, into per-digit segment stores.
module hex_digit_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_i,
  input  logic [6:0] seg_i,
  input  logic       show_i,
  output logic [6:0] hex_o
);
  logic [6:0] store_q, hex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 7'h7F;
      hex_q   <= 7'h7F;
    end else begin
      if (wr_i) store_q <= seg_i;
      hex_q <= show_i ? store_q : 7'h7F;
    end
  end

  assign hex_o = hex_q;
endmodule

module hex_display_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    disp_en,
  output logic                    busy,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] HEX
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]     data_q, data_d;
  logic                           lz_q, lz_d;
  logic                           seen_q, seen_d;
  logic                           done_q, done_d;
  logic [CW-1:0]                  cnt_q;
  logic                           phase_q;
  logic [3:0]                     nib;
  logic [6:0]                     seg_w;
  logic [NUM_DIGITS-1:0][6:0]     hex_w;

  assign busy = (state_q == UPDATE);
  assign done = done_q;
  assign HEX  = hex_w;
  assign nib  = data_q[idx_q];

  always_comb begin
    unique case (nib)
      4'h0: seg_w = 7'b1000000;
      4'h1: seg_w = 7'b1111001;
      4'h2: seg_w = 7'b0100100;
      4'h3: seg_w = 7'b0110000;
      4'h4: seg_w = 7'b0011001;
      4'h5: seg_w = 7'b0010010;
      4'h6: seg_w = 7'b0000010;
      4'h7: seg_w = 7'b1111000;
      4'h8: seg_w = 7'b0000000;
      4'h9: seg_w = 7'b0010000;
      4'hA: seg_w = 7'b0001000;
      4'hB: seg_w = 7'b0000011;
      4'hC: seg_w = 7'b1000110;
      4'hD: seg_w = 7'b0100001;
      4'hE: seg_w = 7'b0000110;
      default: seg_w = 7'b0001110;
    endcase
    // Leading zeros go dark until the first nonzero nibble; digit 0 always shows.
    if (lz_q && nib == 4'h0 && !seen_q && idx_q != '0) seg_w = 7'h7F;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    lz_d    = lz_q;
    seen_d  = seen_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (load) begin
        data_d  = data;
        lz_d    = blank_lz;
        idx_d   = IW'(NUM_DIGITS - 1);
        seen_d  = 1'b0;
        state_d = UPDATE;
      end
      UPDATE: begin
        seen_d = seen_q | (nib != 4'h0);
        if (idx_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      lz_q    <= 1'b0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      lz_q    <= lz_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
    end
  end

  // Free-running blink divider; phase 1 is the dark half.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_lane
    hex_digit_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .wr_i   (busy && idx_q == IW'(d)),
      .seg_i  (seg_w),
      .show_i (disp_en && !(blink_mask[d] && phase_q)),
      .hex_o  (hex_w[d])
    );
  end
endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank with six digits and a short blink divider.
module tb_hex_display_bank;
  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          reset, load, blank_lz, disp_en, busy, done;
  logic [23:0]   data;
  logic [5:0]    blink_mask;
  logic [41:0]   HEX;
  int            checks = 0;
  int            errors = 0;

  localparam logic [41:0] ALL_OFF = {6{7'h7F}};
  localparam logic [41:0] E_PLAIN = {7'h79, 7'h24, 7'h08, 7'h0E, 7'h40, 7'h0E};
  localparam logic [41:0] E_LZ1   = {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
  localparam logic [41:0] E_LZ0   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [41:0] E_ZERO  = {6{7'h40}};
  localparam logic [41:0] E_123   = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

  hex_display_bank #(.NUM_DIGITS(ND), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .blank_lz(blank_lz),
    .blink_mask(blink_mask), .disp_en(disp_en), .busy(busy), .done(done), .HEX(HEX)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load one value and follow it through busy/done to the settled display.
  task automatic run_seq(input string tag, input logic [23:0] d, input logic lz,
                         input logic [41:0] exp);
    int n;
    data = d; blank_lz = lz; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    chk({tag, "_busy_len"}, 64'(n), 64'd6);
    chk({tag, "_done"}, 64'(done), 64'd1);
    tick();
    chk({tag, "_done_clr"}, 64'(done), 64'd0);
    chk({tag, "_hex"}, 64'(HEX), 64'(exp));
  endtask

  initial begin
    int n, first;
    logic saw_done;
    logic [6:0] s [0:23];

    reset = 1'b1; load = 1'b1; data = 24'h777777; blank_lz = 1'b0;
    blink_mask = '0; disp_en = 1'b1;
    tick(); tick();
    chk("rst_hex", 64'(HEX), 64'(ALL_OFF));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0; load = 1'b0;
    tick();
    chk("rst_nocap_busy", 64'(busy), 64'd0);
    chk("rst_nocap_hex", 64'(HEX), 64'(ALL_OFF));

    run_seq("plain", 24'h12AF0F, 1'b0, E_PLAIN);
    run_seq("lz_100", 24'h000100, 1'b1, E_LZ1);
    run_seq("lz_000", 24'h000000, 1'b1, E_LZ0);
    run_seq("nolz_000", 24'h000000, 1'b0, E_ZERO);

    // Load presented in the done cycle is accepted.
    data = 24'h12AF0F; blank_lz = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    chk("dc_done", 64'(done), 64'd1);
    data = 24'h123456; load = 1'b1;
    tick();
    load = 1'b0;
    chk("dc_accept_busy", 64'(busy), 64'd1);
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    tick();
    chk("dc_hex", 64'(HEX), 64'(E_123));

    // Second load while busy must be dropped, not queued.
    data = 24'h12AF0F; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      if (n == 1) begin data = 24'h654321; load = 1'b1; end
      else load = 1'b0;
      n++;
      tick();
    end
    load = 1'b0;
    chk("cont_busy_len", 64'(n), 64'd6);
    chk("cont_done", 64'(done), 64'd1);
    tick();
    chk("cont_hex", 64'(HEX), 64'(E_PLAIN));
    chk("cont_noqueue", 64'(busy), 64'd0);

    disp_en = 1'b0;
    tick();
    chk("en_off", 64'(HEX), 64'(ALL_OFF));
    disp_en = 1'b1;
    tick();
    chk("en_on", 64'(HEX), 64'(E_PLAIN));

    // Digit 0 holds F; expect 4-cycle runs alternating 0E/7F.
    blink_mask = 6'b000001;
    tick();
    for (int i = 0; i < 24; i++) begin
      s[i] = HEX[6:0];
      chk("blink_others", 64'(HEX[41:7]), 64'(E_PLAIN[41:7]));
      tick();
    end
    first = 0;
    for (int i = 4; i >= 1; i--) if (s[i] != s[i-1]) first = i;
    chk("blink_edge_found", 64'(first != 0), 64'd1);
    if (first != 0) begin
      chk("blink_vals", 64'(s[first] ^ s[first-1]), 64'(7'h0E ^ 7'h7F));
      for (int j = first; j < first + 16; j++)
        chk("blink_run", 64'(s[j]), 64'((((j - first) / 4) % 2 == 0) ? s[first] : s[first-1]));
    end
    blink_mask = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("blink_off", 64'(HEX), 64'(E_PLAIN));
      tick();
    end

    // Reset in the third busy cycle aborts with no done pulse.
    data = 24'hFFFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick();
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hex", 64'(HEX), 64'(ALL_OFF));
    chk("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_done |= done;
      tick();
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_hex_after", 64'(HEX), 64'(ALL_OFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
